// File: rtl/prefetch_queue.sv
// rtl/prefetch_queue.sv - byte prefetch queue with one outstanding memory read
// Fetches sequential bytes ahead of the consumer; redirect flushes and restarts fetch.
module prefetch_queue #(
  parameter int                    REG_WIDTH  = 8,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h0000
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      mem_rd,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  input  logic [REG_WIDTH-1:0]      mem_data,
  input  logic                      mem_ack,
  output logic [REG_WIDTH-1:0]      byte_out,
  output logic [ADDR_WIDTH-1:0]     byte_pc,
  output logic                      byte_valid,
  input  logic                      byte_take,
  input  logic                      redirect,
  input  logic [ADDR_WIDTH-1:0]     redirect_pc,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, READ, DISCARD} state_t;

  state_t                 state_q, state_d;
  logic                   mem_rd_q, mem_rd_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0]  byte_pc_q, byte_pc_d;
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [REG_WIDTH-1:0]   mem_q [DEPTH];
  logic                   push;
  logic                   pop;

  always_comb begin
    push       = 1'b0;
    pop        = 1'b0;
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    byte_pc_d  = byte_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    if (redirect) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc;
      byte_pc_d  = redirect_pc;
      // An in-flight read that has not completed must still be drained before refetching.
      if (state_q == IDLE || mem_ack) begin
        state_d    = READ;
        mem_addr_d = redirect_pc;
      end else begin
        state_d = DISCARD;
      end
    end else begin
      pop  = byte_take && (count_q != '0);
      push = (state_q == READ) && mem_ack;
      if (pop) begin
        head_d    = head_q + 1'b1;
        byte_pc_d = byte_pc_q + 1'b1;
      end
      if (push) begin
        tail_d     = tail_q + 1'b1;
        fetch_pc_d = fetch_pc_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      case (state_q)
        IDLE: begin
          if (count_q < DEPTH_C) begin
            state_d    = READ;
            mem_addr_d = fetch_pc_q;
          end
        end
        READ: begin
          if (mem_ack) begin
            if (count_d < DEPTH_C) begin
              mem_addr_d = fetch_pc_q + 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DISCARD: begin
          if (mem_ack) begin
            state_d    = READ;
            mem_addr_d = fetch_pc_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    mem_rd_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      byte_pc_q  <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      fetch_pc_q <= fetch_pc_d;
      byte_pc_q  <= byte_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: an empty queue masks byte_out to zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= mem_data;
    end
  end

  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign byte_pc    = byte_pc_q;
  assign count      = count_q;
  assign byte_valid = (count_q != '0);
  assign byte_out   = byte_valid ? mem_q[head_q] : '0;

endmodule

// File: tb/tb_prefetch_queue.sv
// tb/tb_prefetch_queue.sv - scoreboard bench for prefetch_queue
// Memory responder with random waits, queue-based reference model, decoupled pop monitor.
module tb_prefetch_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [15:0] pc;
    logic [7:0]  data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ack;
  logic [7:0]  byte_out;
  logic [15:0] byte_pc;
  logic        byte_valid;
  logic        byte_take;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [2:0]  count;

  ent_t        mq[$];
  ent_t        exp_q[$];
  logic [7:0]  dq[$];
  int          wait_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          min_w = 0;
  int          max_w = 0;
  int          left  = -1;
  logic        stray = 1'b0;
  logic [15:0] exp_fetch = 16'h0000;
  logic        tainted = 1'b0;

  prefetch_queue dut (
    .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ack(mem_ack), .byte_out(byte_out), .byte_pc(byte_pc),
    .byte_valid(byte_valid), .byte_take(byte_take), .redirect(redirect),
    .redirect_pc(redirect_pc), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_full(input string name);
    int k = 0;
    while (!(count == 3'd4 && !mem_rd) && k < 60) begin
      cyc(1);
      k++;
    end
    chk(name, 32'(count == 3'd4 && !mem_rd), 32'd1);
  endtask

  task automatic do_reset();
    dq.delete();
    wait_q.delete();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask

  // Memory responder: acks each request after a chosen number of wait cycles.
  always begin
    @(posedge clk);
    #1;
    if (reset || stray) begin
      left     = -1;
      mem_ack  = stray;
      mem_data = 8'hEE;
    end else if (mem_rd) begin
      if (left < 0) left = (wait_q.size() != 0) ? wait_q.pop_front() : int'($urandom_range(max_w, min_w));
      if (left == 0) begin
        mem_ack  = 1'b1;
        mem_data = (dq.size() != 0) ? dq.pop_front() : 8'($urandom);
        left     = -1;
      end else begin
        mem_ack = 1'b0;
        left--;
      end
    end else begin
      mem_ack = 1'b0;
    end
  end

  // Reference model: expected queue contents and next fetch address, advanced per edge.
  always begin
    @(negedge clk);
    if (reset) begin
      mq.delete();
      exp_q.delete();
      exp_fetch = 16'h0000;
      tainted   = 1'b0;
    end else begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("byte_valid", 32'(byte_valid), 32'(mq.size() != 0));
      if (mq.size() == 0) chk("byte_out_empty", 32'(byte_out), 32'd0);
      if (mem_rd && !tainted) chk("mem_addr", 32'(mem_addr), 32'(exp_fetch));
      chk("occupancy", 32'(32'(count) + 32'(mem_rd) <= DEPTH), 32'd1);
      if (redirect) begin
        mq.delete();
        exp_fetch = redirect_pc;
        tainted   = mem_rd && !mem_ack;
      end else begin
        if (byte_take && mq.size() != 0) exp_q.push_back(mq.pop_front());
        if (mem_rd && mem_ack) begin
          if (tainted) begin
            tainted = 1'b0;
          end else begin
            mq.push_back('{pc: exp_fetch, data: mem_data});
            exp_fetch = exp_fetch + 16'd1;
          end
        end
      end
    end
  end

  // Monitor: every accepted pop is checked against the scoreboard head.
  always begin
    ent_t e;
    @(negedge clk);
    #1;
    if (!reset && byte_take && byte_valid && !redirect) begin
      chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pop_data", 32'(byte_out), 32'(e.data));
        chk("pop_pc", 32'(byte_pc), 32'(e.pc));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] wpc[3];
    logic [7:0]  wdat[3];
    logic [15:0] a;
    int          k;
    wpc  = '{16'hFFFE, 16'hFFFF, 16'h0000};
    wdat = '{8'h11, 8'h22, 8'h33};
    reset = 1'b0; byte_take = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    mem_ack = 1'b0; mem_data = 8'h00;
    #1 reset = 1'b1;
    #2;
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(byte_valid), 32'd0);
    chk("rst_byte_out", 32'(byte_out), 32'd0);
    chk("rst_byte_pc", 32'(byte_pc), 32'd0);
    dq = '{8'hA9, 8'h05, 8'h8D, 8'h00};
    @(posedge clk);
    #1 reset = 1'b0;

    cyc(1);
    chk("first_rd", 32'(mem_rd), 32'd1);
    chk("first_addr", 32'(mem_addr), 32'd0);
    cyc(5);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_rd", 32'(mem_rd), 32'd0);
    chk("fill_head", 32'(byte_out), 32'hA9);
    chk("fill_pc", 32'(byte_pc), 32'd0);

    byte_take = 1'b1;
    cyc(1);
    chk("take1_out", 32'(byte_out), 32'h05);
    chk("take1_pc", 32'(byte_pc), 32'd1);
    cyc(1);
    chk("take2_out", 32'(byte_out), 32'h8D);
    chk("take2_pc", 32'(byte_pc), 32'd2);
    chk("refetch_rd", 32'(mem_rd), 32'd1);
    chk("refetch_addr", 32'(mem_addr), 32'd4);
    chk("take2_count", 32'(count), 32'd2);
    cyc(1);
    chk("pushpop_count", 32'(count), 32'd2);
    chk("pushpop_pc", 32'(byte_pc), 32'd3);
    chk("pushpop_out", 32'(byte_out), 32'h00);
    byte_take = 1'b0;
    wait_full("refill");

    min_w = 3; max_w = 3;
    byte_take = 1'b1;
    cyc(1);
    byte_take = 1'b0;
    cyc(1);
    chk("slow_rd", 32'(mem_rd), 32'd1);
    a = mem_addr;
    repeat (3) begin
      cyc(1);
      chk("slow_hold_rd", 32'(mem_rd), 32'd1);
      chk("slow_hold_addr", 32'(mem_addr), 32'(a));
      chk("slow_hold_count", 32'(count), 32'd3);
    end
    cyc(1);
    chk("slow_push", 32'(count), 32'd4);
    chk("slow_idle", 32'(mem_rd), 32'd0);
    min_w = 0; max_w = 0;

    do_reset();
    wait_q = '{0, 0, 6};
    k = 0;
    while (!(mem_rd && mem_addr == 16'h0002) && k < 20) begin
      cyc(1);
      k++;
    end
    chk("pend2_seen", 32'(mem_rd && mem_addr == 16'h0002), 32'd1);
    redirect = 1'b1; redirect_pc = 16'h1234;
    cyc(1);
    redirect = 1'b0;
    chk("disc_count", 32'(count), 32'd0);
    chk("disc_pc", 32'(byte_pc), 32'h1234);
    chk("disc_rd", 32'(mem_rd), 32'd1);
    chk("disc_addr_held", 32'(mem_addr), 32'h0002);
    k = 0;
    while (mem_addr != 16'h1234 && k < 20) begin
      cyc(1);
      k++;
    end
    chk("disc_restart", 32'(mem_addr), 32'h1234);
    chk("disc_dropped", 32'(count), 32'd0);

    wait_full("pre_wrap_full");
    dq = '{8'h11, 8'h22, 8'h33, 8'h44};
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    cyc(1);
    redirect = 1'b0;
    wait_full("wrap_full");
    for (int i = 0; i < 3; i++) begin
      chk("wrap_pc", 32'(byte_pc), 32'(wpc[i]));
      chk("wrap_out", 32'(byte_out), 32'(wdat[i]));
      byte_take = 1'b1;
      cyc(1);
    end
    byte_take = 1'b0;

    min_w = 0; max_w = 3;
    for (int i = 0; i < 3000; i++) begin
      byte_take   = 1'($urandom_range(1, 0));
      redirect    = ($urandom_range(31, 0) == 0);
      redirect_pc = ($urandom_range(3, 0) == 0) ? 16'hFFFD + 16'($urandom_range(2, 0)) : 16'($urandom);
      cyc(1);
    end
    byte_take = 1'b0; redirect = 1'b0;

    do_reset();
    wait_q = '{0, 0, 0, 20};
    k = 0;
    while (!(count == 3'd3 && mem_rd) && k < 20) begin
      cyc(1);
      k++;
    end
    chk("mid_three", 32'(count == 3'd3 && mem_rd), 32'd1);
    #2;
    reset = 1'b1; stray = 1'b1;
    #1;
    chk("async_rd", 32'(mem_rd), 32'd0);
    chk("async_addr", 32'(mem_addr), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_valid", 32'(byte_valid), 32'd0);
    chk("async_out", 32'(byte_out), 32'd0);
    chk("async_pc", 32'(byte_pc), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(1);
    chk("stray_ignored", 32'(count), 32'd0);
    chk("post_rst_rd", 32'(mem_rd), 32'd1);
    stray = 1'b0;
    cyc(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter REG_WIDTH SHALL default to 8 and set the data byte width.
REQ-003 Parameter ADDR_WIDTH SHALL default to 16 and set the address width.
REQ-004 Parameter DEPTH SHALL default to 4 and set the queue entries (power of 2, 2..8).
REQ-005 Parameter RESET_PC SHALL default to 16'h0000 and set the fetch and head address after reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 mem_rd  out  1  memory read request; held high until mem_ack.
REQ-009 mem_addr  out  ADDR_WIDTH  read address; stable while mem_rd is high.
REQ-010 mem_data  in  REG_WIDTH  read data; valid only in a cycle with mem_ack high.
REQ-011 mem_ack  in  1  read complete; sampled only while mem_rd is high.
REQ-012 byte_out  out  REG_WIDTH  head byte, driven to the fetcher data_in.
REQ-013 byte_pc  out  ADDR_WIDTH  address of the head byte.
REQ-014 byte_valid  out  1  queue non-empty.
REQ-015 byte_take  in  1  consumer pops the head byte this edge.
REQ-016 redirect  in  1  flush the queue and restart fetch at redirect_pc.
REQ-017 redirect_pc  in  ADDR_WIDTH  new fetch address.
REQ-018 count  out  clog2(DEPTH)+1  number of valid entries.

Function
REQ-019 The FSM SHALL have the states IDLE, READ and DISCARD; mem_rd SHALL equal (state != IDLE).
REQ-020 In IDLE with count < DEPTH and no redirect, the FSM SHALL go to READ at the next edge, with mem_addr = fetch_pc.
REQ-021 In READ with mem_ack and no redirect: mem_data pushes at the tail, fetch_pc increments, and the FSM stays in READ if the post-edge count < DEPTH, otherwise it goes to IDLE.
REQ-022 Zero-wait acks SHALL sustain one byte per cycle.
REQ-023 Only one read SHALL be outstanding; count + outstanding SHALL never exceed DEPTH.
REQ-024 A pop SHALL occur when byte_take and byte_valid are both high; byte_take while empty SHALL be ignored.
REQ-025 A pop SHALL advance the head and increment byte_pc.
REQ-026 A simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-027 byte_valid SHALL equal (count != 0); byte_out SHALL be 0 when empty.
REQ-028 Addresses SHALL wrap modulo 2^ADDR_WIDTH (FFFF+1 = 0000) for fetch_pc and byte_pc.
REQ-029 On redirect: count, head and tail clear; fetch_pc and byte_pc load redirect_pc; byte_take is ignored that edge.
REQ-030 A redirect in IDLE SHALL go to READ next if DEPTH > 0.
REQ-031 A redirect in READ without mem_ack SHALL go to DISCARD, holding mem_rd and the old mem_addr.
REQ-032 In DISCARD, mem_ack SHALL drop mem_data (no push) and go to READ at fetch_pc.
REQ-033 A redirect coincident with mem_ack in READ or DISCARD SHALL drop the data and go to READ at redirect_pc.
REQ-034 A redirect during DISCARD without mem_ack SHALL update fetch_pc and stay in DISCARD.
REQ-035 All outputs except byte_out and byte_valid SHALL be registered.

Reset
REQ-036 Reset assertion SHALL immediately set state=IDLE, count=0, mem_rd=0, mem_addr=RESET_PC, fetch_pc=byte_pc=RESET_PC, byte_out=0, byte_valid=0, queue pointers=0.
REQ-037 Reset mid-read SHALL abandon the request; a later mem_ack SHALL be ignored.
REQ-038 Release SHALL be synchronous to clk; mem_rd SHALL rise on the first edge after release.

Verification
REQ-039 Reset release, zero-wait acks with data 0xA9,0x05,0x8D,0x00, no take -> mem_addr 0000..0003 back-to-back, count=4, mem_rd low, byte_out=0xA9, byte_pc=0000.
REQ-040 Full queue, byte_take held 2 cycles -> byte_out 0x05 then 0x8D, byte_pc 0001 then 0002, refetch of 0004 issued; simultaneous push and pop keeps count.
REQ-041 mem_ack delayed 3 cycles -> mem_addr stable, mem_rd high throughout, single push on the ack cycle.
REQ-042 Redirect to 0x1234 while READ is pending at 0002 -> DISCARD, the late ack's data is not pushed, next mem_addr=0x1234, byte_pc=0x1234, count=0.
REQ-043 Redirect to 0xFFFE, acks 0x11,0x22,0x33 -> addresses FFFE,FFFF,0000; pops show byte_pc FFFE,FFFF,0000.
REQ-044 Reset asserted with 3 entries and a read pending -> all outputs at reset values with no clock edge; a stray mem_ack after release is ignored.
